// File: rtl/audio_peak_sampler.sv
// audio_peak_sampler
//   Synchronises the audio path's sample strobe, takes the magnitude of each
//   signed 8-bit sample and peak-holds it over a window of SAMPLES_PER_INT
//   samples. At the end of each window the peak is published on audio_level
//   and trig_interrupt pulses for one cycle. If a window is published while the
//   previous one is still unacknowledged, the sticky overrun flag is set.
//
// Ports
//   clk            system clock (single domain)
//   reset_n        synchronous active-low reset
//   en             window enable; low holds the block idle and discards the window
//   sample_strobe  asynchronous strobe, rises once per new sample
//   sample_data    signed two's-complement sample, valid >=4 clk after strobe rise
//   intr_ack       processor interrupt acknowledge pulse
//   audio_level    published peak magnitude 0..127 (bit 7 always 0)
//   trig_interrupt one-cycle pulse per published window
//   overrun        sticky, set when a publish finds the previous one unacknowledged
module audio_peak_sampler #(
    parameter int unsigned SAMPLES_PER_INT = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       sample_strobe,
    input  logic [7:0] sample_data,
    input  logic       intr_ack,
    output logic [7:0] audio_level,
    output logic       trig_interrupt,
    output logic       overrun
);

    localparam int unsigned CW = (SAMPLES_PER_INT > 1) ? $clog2(SAMPLES_PER_INT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_INT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic            r_tick;
    logic [6:0]      r_peak;
    logic [6:0]      r_pub;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_level;
    logic            r_trig;
    logic            r_pending;
    logic            r_overrun;

    logic [6:0]      w_neg;
    logic [6:0]      w_mag;
    logic [6:0]      w_max;

    // Magnitude of the current sample; -128 has no positive 8-bit peer and
    // saturates to 127.
    always_comb begin
        w_neg = (~sample_data[6:0]) + 7'd1;
        if (!sample_data[7]) begin
            w_mag = sample_data[6:0];
        end else if (sample_data[6:0] == 7'd0) begin
            w_mag = 7'h7F;
        end else begin
            w_mag = w_neg;
        end
        w_max = (w_mag > r_peak) ? w_mag : r_peak;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next = ACCUM;
                end
            end
            ACCUM: begin
                if (!en) begin
                    w_next = IDLE;
                end else if (r_tick && (r_count == LAST)) begin
                    w_next = PUBLISH;
                end
            end
            PUBLISH: begin
                w_next = en ? ACCUM : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The edge detect (s2 & ~s3) is registered into r_tick so the sample is
    // consumed one edge later, giving sample_data its settling time and the
    // 5-clk strobe-to-interrupt latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_tick    <= 1'b0;
            r_peak    <= '0;
            r_pub     <= '0;
            r_count   <= '0;
            r_level   <= '0;
            r_trig    <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_s1   <= sample_strobe;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_tick <= r_s2 & ~r_s3;
            r_trig <= (r_state == PUBLISH);

            case (r_state)
                ACCUM: begin
                    if (!en) begin
                        r_peak  <= '0;
                        r_count <= '0;
                    end else if (r_tick) begin
                        if (r_count == LAST) begin
                            r_pub   <= w_max;
                            r_peak  <= '0;
                            r_count <= '0;
                        end else begin
                            r_peak  <= w_max;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    r_level <= {1'b0, r_pub};
                    // A tick landing here starts the next window as sample 0.
                    if (en && r_tick) begin
                        r_peak  <= w_mag;
                        r_count <= CW'(1);
                    end else begin
                        r_peak  <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_peak  <= '0;
                    r_count <= '0;
                end
            endcase

            // Publish takes priority over a coincident acknowledge; overrun
            // looks at pending as it stood before this edge.
            if (r_state == PUBLISH) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
                r_pending <= 1'b1;
            end else if (intr_ack) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign audio_level    = r_level;
    assign trig_interrupt = r_trig;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_audio_peak_sampler.sv
// tb_audio_peak_sampler
//   Directed bench for audio_peak_sampler with a 4-sample window. Inputs are
//   driven on the falling edge; outputs are sampled on the falling edge.
module tb_audio_peak_sampler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       sample_strobe;
    logic [7:0] sample_data;
    logic       intr_ack;
    logic [7:0] audio_level;
    logic       trig_interrupt;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int trig_cnt = 0;
    int trig_hi  = 0;
    int exp_trig = 0;
    int lat;
    logic trig_prev = 1'b0;

    always #5 clk = ~clk;

    audio_peak_sampler #(.SAMPLES_PER_INT(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .sample_strobe  (sample_strobe),
        .sample_data    (sample_data),
        .intr_ack       (intr_ack),
        .audio_level    (audio_level),
        .trig_interrupt (trig_interrupt),
        .overrun        (overrun)
    );

    always @(negedge clk) begin
        if (trig_interrupt) trig_hi++;
        if (trig_interrupt && !trig_prev) trig_cnt++;
        trig_prev = trig_interrupt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the strobe at a falling edge, hold it for 'hold' cycles, then keep
    // it low. lat = falling edges from strobe rise to first trig seen (-1 none).
    // intr_ack is high across the rising edge following falling edge 'ack_at'.
    task automatic send_sample(input logic [7:0] d, input int hold, input int ack_at,
                               output int l);
        l = -1;
        @(negedge clk);
        sample_data   = d;
        sample_strobe = 1'b1;
        for (int i = 1; i <= hold + 8; i++) begin
            @(negedge clk);
            if (trig_interrupt && l < 0) l = i;
            intr_ack = (i == ack_at);
            if (i == hold) sample_strobe = 1'b0;
        end
        intr_ack = 1'b0;
    endtask

    task automatic window4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input int ack_at, output int l);
        int dummy;
        send_sample(a, 4, -1, dummy);
        send_sample(b, 4, -1, dummy);
        send_sample(c, 4, -1, dummy);
        send_sample(d, 4, ack_at, l);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int d;
        reset_n       = 1'b0;
        en            = 1'b0;
        sample_strobe = 1'b0;
        sample_data   = 8'h00;
        intr_ack      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(audio_level), 32'h00);
        chk("rst_trig", 32'(trig_interrupt), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        en      = 1'b1;

        // 1: no strobes
        repeat (1000) @(negedge clk);
        chk("idle_trig_hi", 32'(trig_hi), 32'd0);
        chk("idle_level", 32'(audio_level), 32'h00);
        chk("idle_ovr", 32'(overrun), 32'h0);

        // 2: 05, F0, 20, FF -> 0x20
        window4(8'h05, 8'hF0, 8'h20, 8'hFF, -1, lat);
        exp_trig++;
        chk("w2_latency", 32'(lat), 32'd5);
        chk("w2_trigs", 32'(trig_cnt), 32'(exp_trig));
        chk("w2_level", 32'(audio_level), 32'h20);
        chk("w2_ovr", 32'(overrun), 32'h0);

        // 3: saturation, long strobe counts once
        pulse_ack();
        send_sample(8'h80, 50, -1, d);
        send_sample(8'h01, 4, -1, d);
        send_sample(8'h02, 4, -1, d);
        chk("w3_no_early_trig", 32'(trig_cnt), 32'(exp_trig));
        chk("w3_level_hold", 32'(audio_level), 32'h20);
        send_sample(8'h03, 4, -1, lat);
        exp_trig++;
        chk("w3_latency", 32'(lat), 32'd5);
        chk("w3_trigs", 32'(trig_cnt), 32'(exp_trig));
        chk("w3_level_sat", 32'(audio_level), 32'h7F);
        chk("w3_ovr", 32'(overrun), 32'h0);

        // 4: two windows without ack -> overrun, sticky until reset
        pulse_ack();
        window4(8'h11, 8'h22, 8'hC0, 8'h44, -1, lat);
        exp_trig++;
        chk("w4a_level", 32'(audio_level), 32'h44);
        chk("w4a_ovr", 32'(overrun), 32'h0);
        window4(8'h7F, 8'h00, 8'h81, 8'h10, -1, lat);
        exp_trig++;
        chk("w4b_level", 32'(audio_level), 32'h7F);
        chk("w4b_ovr", 32'(overrun), 32'h1);
        pulse_ack();
        window4(8'h01, 8'h02, 8'hFE, 8'h03, -1, lat);
        exp_trig++;
        chk("w4c_level", 32'(audio_level), 32'h03);
        chk("w4c_ovr_sticky", 32'(overrun), 32'h1);
        chk("w4_trigs", 32'(trig_cnt), 32'(exp_trig));
        do_reset();
        chk("w4_rst_ovr", 32'(overrun), 32'h0);
        chk("w4_rst_level", 32'(audio_level), 32'h00);

        // 5: acked windows, then ack coincident with publish
        window4(8'h08, 8'h09, 8'h0A, 8'h0B, -1, lat);
        exp_trig++;
        pulse_ack();
        window4(8'h18, 8'hE8, 8'h0A, 8'h0B, -1, lat);
        exp_trig++;
        chk("w5a_level", 32'(audio_level), 32'h18);
        chk("w5a_ovr", 32'(overrun), 32'h0);
        pulse_ack();
        window4(8'h30, 8'h31, 8'h32, 8'h33, 4, lat);
        exp_trig++;
        chk("w5b_latency", 32'(lat), 32'd5);
        chk("w5b_ovr", 32'(overrun), 32'h0);
        window4(8'h40, 8'h41, 8'h42, 8'h43, -1, lat);
        exp_trig++;
        chk("w5c_ovr_pend_kept", 32'(overrun), 32'h1);
        chk("w5_trigs", 32'(trig_cnt), 32'(exp_trig));
        do_reset();

        // 6: en drop discards partial window; reset mid-window
        send_sample(8'h7F, 4, -1, d);
        send_sample(8'h7E, 4, -1, d);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        send_sample(8'h10, 4, -1, d);
        send_sample(8'h20, 4, -1, d);
        send_sample(8'h30, 4, -1, d);
        chk("w6_no_trig_after_en", 32'(trig_cnt), 32'(exp_trig));
        send_sample(8'h05, 4, -1, lat);
        exp_trig++;
        chk("w6_latency", 32'(lat), 32'd5);
        chk("w6_trigs", 32'(trig_cnt), 32'(exp_trig));
        chk("w6_level", 32'(audio_level), 32'h30);
        chk("w6_ovr", 32'(overrun), 32'h0);
        send_sample(8'h50, 4, -1, d);
        send_sample(8'h60, 4, -1, d);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("w6_rst_level", 32'(audio_level), 32'h00);
        chk("w6_rst_ovr", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        send_sample(8'h11, 4, -1, d);
        send_sample(8'h22, 4, -1, d);
        chk("w6_rst_no_trig", 32'(trig_cnt), 32'(exp_trig));
        send_sample(8'h33, 4, -1, d);
        send_sample(8'h44, 4, -1, lat);
        exp_trig++;
        chk("w6_post_rst_trigs", 32'(trig_cnt), 32'(exp_trig));
        chk("w6_post_rst_level", 32'(audio_level), 32'h44);
        chk("pulse_width", 32'(trig_hi), 32'(trig_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_peak_sampler.md
Name: audio_peak_sampler

Overview:
- Upstream feeder for the PicoBlaze LED-intensity controller.
- Takes the slow 8-bit signed audio sample stream from the flash/audio path and synchronises its sample strobe.
- Computes per-sample magnitude and peak-holds it over a fixed window of samples.
- Publishes the peak as a stable `audio_level` byte (to the processor's port-0 input) and issues a one-cycle `trig_interrupt` pulse per window.
- Tracks the processor's interrupt acknowledge and flags an overrun if a window completes before the previous one is acknowledged.

Parameters:
- SAMPLES_PER_INT, 256, number of sample ticks per peak window (≥2); counter width = clog2(SAMPLES_PER_INT).

Ports:
- clk  input  1  system clock; all logic in this single domain.
- reset_n  input  1  synchronous active-low reset, sampled on rising clk.
- en  input  1  window enable; low holds the block idle.
- sample_strobe  input  1  level toggle-high per new sample from the audio path; treated as asynchronous.
- sample_data  input  8  signed two's-complement audio sample; stable ≥4 clk after strobe rising edge.
- intr_ack  input  1  processor interrupt acknowledge pulse.
- audio_level  output  8  published peak magnitude, 0..127 (bit 7 always 0).
- trig_interrupt  output  1  one-cycle pulse per published window.
- overrun  output  1  sticky: window published while previous still unacknowledged.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - audio_level=0, trig_interrupt=0, overrun=0.
  - peak=0, count=0, pending=0, sync flops=0, state=IDLE.
- Strobe synchroniser and tick:
  - sample_strobe passes through 2 flops (s1, s2) plus a third flop s3.
  - tick = s2 & ~s3, exactly one cycle per rising edge.
  - A strobe held high yields a single tick.
  - tick asserts on the 3rd clk edge after the strobe rises.
- Magnitude (captured on tick):
  - data[7]=0: mag = data.
  - data[7]=1: mag = -data.
  - 8'h80 (−128) saturates to 127.
  - mag is 7 bits.
- State machine:
  - IDLE: peak=0, count=0; ticks ignored. Go to ACCUM when en=1.
  - ACCUM, on tick:
    - m = max(peak, mag).
    - If count == SAMPLES_PER_INT−1: latch m into publish register, peak<=0, count<=0, go to PUBLISH.
    - Otherwise: peak<=m, count<=count+1.
    - Leaving en=0 (any cycle) → IDLE, which discards the partial window.
  - PUBLISH (exactly one cycle):
    - audio_level <= {1'b0, publish_reg}.
    - trig_interrupt=1 (registered; high during the cycle after PUBLISH is entered, for one cycle).
    - If pending==1 already, overrun<=1.
    - pending<=1.
    - Return to ACCUM if en=1, else IDLE.
    - A tick arriving in this cycle is not lost: it is accumulated as sample 0 of the next window.
- Timing and stability:
  - audio_level changes only on publish and is stable between publishes.
  - Latency from the window's last strobe rising edge to trig_interrupt high: 5 clk.
- Acknowledge:
  - intr_ack=1 clears pending on the next edge.
  - If intr_ack coincides with a publish, the publish wins: pending=1, and overrun is evaluated on the pre-ack pending value.
- overrun is cleared only by reset.
- reset_n low mid-window forces all reset values on that edge; no trig_interrupt is emitted.
- No combinational path from any input to any output.

Test Plan:
1. Reset, release, en=1, no strobes for 1000 clk -> audio_level=0, trig_interrupt never high, overrun=0.
2. SAMPLES_PER_INT=4; samples 8'h05, 8'hF0 (−16), 8'h20, 8'hFF -> exactly one trig pulse 5 clk after 4th strobe edge; audio_level=8'h20; pending set.
3. Window containing 8'h80 and 8'h7F -> audio_level=8'h7F (saturation). A strobe held high for 50 clk counts as one sample.
4. Two windows with no intr_ack -> overrun=1 after second trig. Then intr_ack, a third window and reset -> overrun stays 1 until reset, then 0.
5. intr_ack after first trig, then second window -> overrun stays 0. intr_ack asserted in the same cycle as a publish -> pending=1, overrun per prior pending.
6. en dropped after 2 of 4 samples, then raised, 4 new samples -> one trig; audio_level reflects only the 4 new samples. reset_n pulsed mid-window -> no trig, outputs zero.
